// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, prefetches one instruction from a
// 1-cycle-latency imem, and serves decode over f2d / takes redirects on d2f.
// Optional macro FETCH_SEQ_TAG_EN adds a 22-bit handshake sequence tag in f2d[31:10].
module fetch_stage (
   input  logic        clk,
   input  logic        Z_R,
   output logic [9:0]  imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   input  logic        f2d_R,
   output logic        f2d_A,
   output logic [63:0] f2d,
   input  logic        d2f_R,
   output logic        d2f_A,
   input  logic [32:0] d2f
);

   typedef enum logic {F_IDLE, F_ACK} f_state_t;
   typedef enum logic {D_IDLE, D_ACK} d_state_t;

   f_state_t    r_f_state;
   f_state_t    w_f_next;
   d_state_t    r_d_state;
   d_state_t    w_d_next;

   logic [9:0]  r_pc;
   logic [31:0] r_buf;
   logic        r_buf_v;
   logic        r_rd_pend;
   logic        r_drop;
   logic        r_redir_hold;
   logic [63:0] r_f2d;

   logic        w_f_start;
   logic        w_f_end;
   logic        w_redirect;
   logic        w_issue;
   logic [9:0]  w_pc_inc;
   logic [21:0] w_tag;
   logic        w_unused;

   assign w_unused = &{1'b0, d2f[31:10], d2f[1:0]};

   assign w_pc_inc  = r_pc + 10'd4;
   assign w_issue   = !Z_R && !r_buf_v && !r_rd_pend && (r_f_state == F_IDLE);
   assign imem_en   = w_issue;
   assign imem_addr = {2'b00, r_pc[9:2]};
   assign f2d_A     = (r_f_state == F_ACK);
   assign d2f_A     = (r_d_state == D_ACK);
   assign f2d       = r_f2d;

`ifdef FETCH_SEQ_TAG_EN
   logic [21:0] r_tag;

   always_ff @(posedge clk) begin
      if (Z_R) begin
         r_tag <= '0;
      end else if (w_f_end) begin
         r_tag <= r_tag + 22'd1;
      end
   end

   assign w_tag = r_tag;
`else
   assign w_tag = '0;
`endif

   always_comb begin
      w_f_next  = r_f_state;
      w_f_start = 1'b0;
      w_f_end   = 1'b0;
      case (r_f_state)
         F_IDLE: begin
            if (f2d_R && r_buf_v) begin
               w_f_next  = F_ACK;
               w_f_start = 1'b1;
            end
         end
         F_ACK: begin
            if (!f2d_R) begin
               w_f_next = F_IDLE;
               w_f_end  = 1'b1;
            end
         end
         default: w_f_next = F_IDLE;
      endcase
   end

   always_comb begin
      w_d_next   = r_d_state;
      w_redirect = 1'b0;
      case (r_d_state)
         D_IDLE: begin
            if (d2f_R) begin
               w_d_next   = D_ACK;
               w_redirect = d2f[32];
            end
         end
         D_ACK: begin
            if (!d2f_R) begin
               w_d_next = D_IDLE;
            end
         end
         default: w_d_next = D_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Z_R) begin
         r_f_state    <= F_IDLE;
         r_d_state    <= D_IDLE;
         r_pc         <= '0;
         r_buf        <= '0;
         r_buf_v      <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_drop       <= 1'b0;
         r_redir_hold <= 1'b0;
         r_f2d        <= '0;
      end else begin
         r_f_state <= w_f_next;
         r_d_state <= w_d_next;
         r_rd_pend <= w_issue;
         // A read issued under a redirect fetched the old PC; mark it for discard.
         r_drop    <= w_issue && w_redirect;

         if (w_redirect) begin
            r_pc <= {d2f[9:2], 2'b00};
         end else if (w_f_end && !r_redir_hold) begin
            r_pc <= w_pc_inc;
         end

         if (w_redirect || w_f_end) begin
            r_buf_v <= 1'b0;
         end else if (r_rd_pend && !r_drop) begin
            r_buf_v <= 1'b1;
         end

         if (r_rd_pend && !r_drop && !w_redirect) begin
            r_buf <= imem_rdata;
         end

         // Remembers a redirect taken while an f2d word is held so the exit
         // does not step the PC past the new target.
         if (w_f_end) begin
            r_redir_hold <= 1'b0;
         end else if (w_redirect && ((r_f_state == F_ACK) || w_f_start)) begin
            r_redir_hold <= 1'b1;
         end

         if (w_f_start) begin
            r_f2d <= {r_buf, w_tag, w_pc_inc};
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed handshakes push expected f2d words
// and imem addresses; a negedge monitor pops and compares them.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        Z_R = 1'b1;
   logic [9:0]  imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata = '0;
   logic        f2d_R = 1'b0;
   logic        f2d_A;
   logic [63:0] f2d;
   logic        d2f_R = 1'b0;
   logic        d2f_A;
   logic [32:0] d2f = '0;

   logic [31:0] mem [0:1023];
   logic [63:0] exp_q[$];
   logic [9:0]  addr_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [21:0] exp_tag = '0;
   logic        prev_a = 1'b0;
   logic [63:0] mon_e;
   logic [9:0]  mon_a;

   fetch_stage dut (
      .clk        (clk),
      .Z_R        (Z_R),
      .imem_addr  (imem_addr),
      .imem_en    (imem_en),
      .imem_rdata (imem_rdata),
      .f2d_R      (f2d_R),
      .f2d_A      (f2d_A),
      .f2d        (f2d),
      .d2f_R      (d2f_R),
      .d2f_A      (d2f_A),
      .d2f        (d2f)
   );

   // clock / reset / memory model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [31:0] instr, input logic [9:0] npc);
`ifdef FETCH_SEQ_TAG_EN
      return {instr, exp_tag, npc};
`else
      return {instr, 22'b0, npc};
`endif
   endfunction

   task automatic wait_f2d_A(input logic val);
      int k = 0;
      while (f2d_A !== val && k < 40) begin tick(); k++; end
      if (f2d_A !== val) begin
         n_cmp++; n_fail++;
         $display("FAIL f2d_A_timeout: got %b want %b", f2d_A, val);
      end
   endtask

   task automatic wait_d2f_A(input logic val);
      int k = 0;
      while (d2f_A !== val && k < 40) begin tick(); k++; end
      if (d2f_A !== val) begin
         n_cmp++; n_fail++;
         $display("FAIL d2f_A_timeout: got %b want %b", d2f_A, val);
      end
   endtask

   task automatic wait_imem_en();
      int k = 0;
      while (imem_en !== 1'b1 && k < 40) begin tick(); k++; end
      if (imem_en !== 1'b1) begin
         n_cmp++; n_fail++;
         $display("FAIL imem_en_timeout: got %b want 1", imem_en);
      end
   endtask

   // driver tasks
   task automatic f2d_start(input logic [31:0] instr, input logic [9:0] npc);
      exp_q.push_back(mk(instr, npc));
      f2d_R = 1'b1;
      wait_f2d_A(1'b1);
   endtask

   task automatic f2d_end();
      f2d_R = 1'b0;
      wait_f2d_A(1'b0);
      exp_tag = exp_tag + 22'd1;
   endtask

   task automatic f2d_hs(input logic [31:0] instr, input logic [9:0] npc);
      f2d_start(instr, npc);
      f2d_end();
      idle(3);
   endtask

   task automatic d2f_hs(input logic redir, input logic [31:0] tgt);
      d2f   = {redir, tgt};
      d2f_R = 1'b1;
      wait_d2f_A(1'b1);
      d2f_R = 1'b0;
      wait_d2f_A(1'b0);
      idle(3);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (f2d_A === 1'b1 && prev_a !== 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL f2d_unexpected: got %h want none", f2d);
         end else begin
            mon_e = exp_q.pop_front();
            check64("f2d_word", f2d, mon_e);
         end
      end
      prev_a <= f2d_A;
      if (imem_en === 1'b1 && addr_q.size() > 0) begin
         mon_a = addr_q.pop_front();
         check64("imem_addr", {54'b0, imem_addr}, {54'b0, mon_a});
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;

      // reset state
      idle(3);
      check64("rst_f2d_A", {63'b0, f2d_A}, 64'd0);
      check64("rst_d2f_A", {63'b0, d2f_A}, 64'd0);
      check64("rst_imem_en", {63'b0, imem_en}, 64'd0);
      check64("rst_f2d", f2d, 64'd0);

      // sequential stream
      addr_q.push_back(10'd0);
      addr_q.push_back(10'd1);
      addr_q.push_back(10'd2);
      Z_R = 1'b0;
      f2d_hs(32'h1111_1111, 10'd4);
      f2d_hs(32'h2222_2222, 10'd8);
      f2d_hs(32'h3333_3333, 10'd12);

      // wrap of next_pc at the top of the PC range
      addr_q.push_back(10'd255);
      addr_q.push_back(10'd0);
      d2f_hs(1'b1, 32'h0000_03FC);
      f2d_hs(mem[255], 10'd0);
      f2d_hs(32'h1111_1111, 10'd4);

      // redirect sampled in the read-issue cycle: that read is discarded
      addr_q.push_back(10'd2);
      addr_q.push_back(10'd16);
      f2d_start(32'h2222_2222, 10'd8);
      f2d_end();
      wait_imem_en();
      d2f   = {1'b1, 32'h0000_0040};
      d2f_R = 1'b1;
      wait_d2f_A(1'b1);
      d2f_R = 1'b0;
      wait_d2f_A(1'b0);
      f2d_hs(mem[16], 10'h044);

      // non-redirect d2f leaves the stream alone
      d2f_hs(1'b0, 32'h0000_0080);
      f2d_hs(mem[17], 10'h048);

      // redirect in the same cycle as the F_ACK exit
      addr_q.push_back(10'd64);
      f2d_start(mem[18], 10'h04C);
      f2d_R = 1'b0;
      d2f   = {1'b1, 32'h0000_0100};
      d2f_R = 1'b1;
      wait_d2f_A(1'b1);
      exp_tag = exp_tag + 22'd1;
      d2f_R = 1'b0;
      wait_d2f_A(1'b0);
      idle(3);
      f2d_hs(mem[64], 10'h104);

      // redirect while the f2d word is held, exit later
      f2d_start(mem[65], 10'h108);
      d2f_hs(1'b1, 32'h0000_0200);
      addr_q.push_back(10'd128);
      f2d_end();
      idle(3);
      f2d_hs(mem[128], 10'h204);

      // reset with both acknowledges high
      f2d_start(mem[129], 10'h208);
      d2f   = '0;
      d2f_R = 1'b1;
      wait_d2f_A(1'b1);
      Z_R = 1'b1;
      tick();
      check64("rst_mid_f2d_A", {63'b0, f2d_A}, 64'd0);
      check64("rst_mid_d2f_A", {63'b0, d2f_A}, 64'd0);
      check64("rst_mid_f2d", f2d, 64'd0);
      f2d_R = 1'b0;
      d2f_R = 1'b0;
      exp_tag = '0;
      idle(2);
      addr_q.push_back(10'd0);
      Z_R = 1'b0;
      f2d_hs(32'h1111_1111, 10'd4);
      f2d_hs(32'h2222_2222, 10'd8);

      idle(5);
      check64("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check64("addr_q_drained", 64'(addr_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
